// File: rtl/packet_receiver.sv
`default_nettype none
// ============================================================================
// Module   : packet_receiver
// Purpose  : UART 8N1 receiver that gathers PACKET_SIZE bytes into one wide
//            packet word, with an inter-byte timeout and framing-error
//            recovery so partial or corrupt frames never reach the consumer.
// Revision : 1.0 - initial release
// ============================================================================
module packet_receiver #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned PACKET_SIZE  = 16'd9,
  parameter int unsigned TIMEOUT_CLKS = 32'd12000
) (
  input  logic                     hwclk,
  input  logic                     rst,
  input  logic                     rxd,
  output logic [8*PACKET_SIZE-1:0] packet,
  output logic                     valid,
  output logic                     busy,
  output logic                     frame_err,
  output logic                     timeout
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam int            PW        = 8 * PACKET_SIZE;
  localparam logic [CW-1:0] MID       = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST      = CW'(CLKS_PER_BIT - 1);
  localparam logic [15:0]   LAST_BYTE = 16'(PACKET_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t          state;
  logic            rx_meta;
  logic            rx_s;
  logic [CW-1:0]   bit_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift_byte;
  logic [15:0]     byte_count;
  logic [31:0]     idle_cnt;
  logic [PW-1:0]   stage;
  logic [PW-1:0]   stage_next;

  // The staging buffer shifts left one byte per committed byte, so after a
  // full packet the first byte sits in the MSB byte and the last in [7:0].
  // Stale bytes from a discarded partial packet are pushed out entirely by
  // the next PACKET_SIZE bytes, so no explicit clear is needed.
  generate
    if (PACKET_SIZE > 1) begin : g_multi_byte
      assign stage_next = {stage[PW-9:0], shift_byte};
    end else begin : g_single_byte
      assign stage_next = shift_byte;
    end
  endgenerate

  // Busy whenever a byte is in flight or a partial packet is held.
  assign busy = (state != IDLE) || (byte_count != 16'd0);

  // Two-flop synchroniser for the asynchronous line; idles high.
  always_ff @(posedge hwclk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_s    <= rx_meta;
    end
  end

  // Receive state machine: bit timing, byte assembly, packet commit and the
  // timeout / framing-error recovery paths.
  always_ff @(posedge hwclk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      bit_idx    <= 3'd0;
      shift_byte <= 8'd0;
      byte_count <= 16'd0;
      idle_cnt   <= 32'd0;
      stage      <= '0;
      packet     <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      timeout   <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state    <= START;
            bit_cnt  <= '0;
            idle_cnt <= 32'd0;
          end else if (byte_count != 16'd0) begin
            if (idle_cnt + 32'd1 == TIMEOUT_CLKS) begin
              byte_count <= 16'd0;
              timeout    <= 1'b1;
              idle_cnt   <= 32'd0;
            end else begin
              idle_cnt <= idle_cnt + 32'd1;
            end
          end
        end
        START: begin
          if (bit_cnt == MID) begin
            // A line that is high again at mid-start-bit was only a glitch.
            if (rx_s) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              bit_idx <= 3'd0;
              bit_cnt <= '0;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_cnt == LAST) begin
            bit_cnt             <= '0;
            shift_byte[bit_idx] <= rx_s;
            bit_idx             <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_cnt == LAST) begin
            bit_cnt <= '0;
            if (rx_s) begin
              // Back to IDLE right away so a back-to-back start bit is seen.
              stage <= stage_next;
              state <= IDLE;
              if (byte_count == LAST_BYTE) begin
                packet     <= stage_next;
                valid      <= 1'b1;
                byte_count <= 16'd0;
              end else begin
                byte_count <= byte_count + 16'd1;
              end
            end else begin
              frame_err  <= 1'b1;
              byte_count <= 16'd0;
              state      <= BREAK;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        BREAK: begin
          // Hold off until the line returns high so a break yields no bytes.
          if (rx_s) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_packet_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_packet_receiver
// Purpose  : Scoreboard bench for packet_receiver with directed UART frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_packet_receiver;

  localparam int CPB = 4;
  localparam int PS  = 9;
  localparam int TO  = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rxd = 1'b1;
  logic [71:0] packet;
  logic        valid;
  logic        busy;
  logic        frame_err;
  logic        timeout;

  packet_receiver #(
    .CLKS_PER_BIT (CPB),
    .PACKET_SIZE  (PS),
    .TIMEOUT_CLKS (TO)
  ) dut (
    .hwclk     (clk),
    .rst       (rst),
    .rxd       (rxd),
    .packet    (packet),
    .valid     (valid),
    .busy      (busy),
    .frame_err (frame_err),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  // Expected event: kind is one-hot {valid, frame_err, timeout}.
  typedef struct packed {
    logic [2:0]  kind;
    logic [71:0] pkt;
  } exp_t;

  localparam logic [2:0] K_VALID = 3'b100;
  localparam logic [2:0] K_FERR  = 3'b010;
  localparam logic [2:0] K_TOUT  = 3'b001;

  exp_t        sb[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [71:0] cur_pkt = '0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Pops one expectation per output event and compares it.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (valid || frame_err || timeout)) begin
        check("event_onehot", 72'($countones({valid, frame_err, timeout})), 72'd1);
        if (sb.size() == 0) begin
          check("unexpected_event", {69'd0, valid, frame_err, timeout}, 72'd0);
        end else begin
          e = sb.pop_front();
          check("event_kind", {69'd0, valid, frame_err, timeout}, {69'd0, e.kind});
          check("event_packet", packet, e.pkt);
        end
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int gap_bits);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
    repeat (gap_bits * CPB) @(negedge clk);
  endtask

  task automatic send_packet(input logic [71:0] p, input int gap_bits);
    sb.push_back({K_VALID, p});
    cur_pkt = p;
    for (int i = 0; i < PS; i++) begin
      send_byte(p[71-8*i -: 8], 1'b1, gap_bits);
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 3000 && sb.size() != 0; i++) @(negedge clk);
    check(name, 72'(sb.size()), 72'd0);
    repeat (2 * CPB) @(negedge clk);
  endtask

  initial begin
    fork
      monitor();
    join_none

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_packet", packet, 72'd0);
    check("rst_flags", {68'd0, valid, busy, frame_err, timeout}, 72'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // One packet with one idle bit between bytes
    send_packet("123456789", 1);
    drain("t1_drain");
    check("t1_packet_hex", packet, 72'h313233343536373839);
    check("t1_busy_idle", 72'(busy), 72'd0);

    // Two packets back-to-back with no idle bits
    send_packet("ABCDEFGHI", 0);
    send_packet("abcdefghi", 0);
    drain("t2_drain");

    // Start-bit glitch shorter than half a bit
    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    repeat (CPB + 3) @(negedge clk);
    check("t3_busy_after_glitch", 72'(busy), 72'd0);
    send_packet("123456789", 1);
    drain("t3_drain");

    // Framing error then a good packet
    sb.push_back({K_FERR, cur_pkt});
    send_byte(8'h55, 1'b0, 3);
    check("t4_busy_after_ferr", 72'(busy), 72'd0);
    send_packet("123456789", 1);
    drain("t4_drain");

    // Partial packet dropped on timeout, packet unchanged at the timeout
    for (int i = 0; i < 4; i++) send_byte(8'h57 + 8'(i), 1'b1, 1);
    check("t5_busy_partial", 72'(busy), 72'd1);
    sb.push_back({K_TOUT, cur_pkt});
    repeat (TO + 10) @(negedge clk);
    check("t5_busy_after_timeout", 72'(busy), 72'd0);
    send_packet("987654321", 1);
    drain("t5_drain");

    // Reset in the middle of a packet
    for (int i = 0; i < 5; i++) send_byte(8'h61 + 8'(i), 1'b1, 1);
    check("t6_busy_partial", 72'(busy), 72'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_rst_packet", packet, 72'd0);
    check("t6_rst_flags", {68'd0, valid, busy, frame_err, timeout}, 72'd0);
    cur_pkt = '0;
    send_packet("qrstuvwxy", 1);
    drain("t6_drain");

    repeat (20) @(negedge clk);
    check("final_scoreboard_empty", 72'(sb.size()), 72'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
